// File: rtl/wave_capture.sv
// Zero-crossing triggered capture of 256 samples into a double-buffered display RAM.
// Optional TRIGGER_TIMEOUT_EN: force a trigger after TIMEOUT_SAMPLES samples spent waiting in ARMED.
module wave_capture #(
`ifdef TRIGGER_TIMEOUT_EN
  parameter int TIMEOUT_SAMPLES = 1024,
`endif
  parameter int ADDR_W      = 8,
  parameter int NUM_SAMPLES = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_sample_ready,
  input  logic [15:0]       new_sample_in,
  input  logic              wave_display_idle,
  output logic [ADDR_W:0]   write_address,
  output logic              write_enable,
  output logic [7:0]        write_sample,
  output logic              read_index
);

  typedef enum logic [1:0] {S_ARMED, S_ACTIVE, S_WAIT} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_index;
  logic                r_prev_neg;
  logic                r_read_index;
  logic                r_we;
  logic [ADDR_W:0]     r_addr;
  logic [7:0]          r_data;

  logic                w_trig;
  logic [7:0]          w_sample;
  logic                w_unused;

  // Only the sign of the previous sample matters for crossing detection.
  assign w_sample = {~new_sample_in[15], new_sample_in[14:8]};
  assign w_unused = ^new_sample_in[7:0];

`ifdef TRIGGER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_SAMPLES + 1);
  logic [CNT_W-1:0] r_arm_cnt;
  assign w_trig = (r_prev_neg & ~new_sample_in[15]) |
                  (r_arm_cnt == CNT_W'(TIMEOUT_SAMPLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_arm_cnt <= '0;
    end else if (r_state == S_ARMED && new_sample_ready) begin
      r_arm_cnt <= w_trig ? '0 : r_arm_cnt + 1'b1;
    end
  end
`else
  assign w_trig = r_prev_neg & ~new_sample_in[15];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_ARMED;
      r_index      <= '0;
      r_prev_neg   <= 1'b0;
      r_read_index <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_we <= 1'b0;
      if (new_sample_ready) r_prev_neg <= new_sample_in[15];
      case (r_state)
        S_ARMED: begin
          if (new_sample_ready && w_trig) begin
            r_we    <= 1'b1;
            r_addr  <= {~r_read_index, {ADDR_W{1'b0}}};
            r_data  <= w_sample;
            r_index <= ADDR_W'(1);
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (new_sample_ready) begin
            r_we    <= 1'b1;
            r_addr  <= {~r_read_index, r_index};
            r_data  <= w_sample;
            r_index <= r_index + 1'b1;
            if (r_index == ADDR_W'(NUM_SAMPLES - 1)) r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Swap banks only while the display is not drawing.
          if (wave_display_idle) begin
            r_read_index <= ~r_read_index;
            r_state      <= S_ARMED;
          end
        end
        default: r_state <= S_ARMED;
      endcase
    end
  end

  assign write_address = r_addr;
  assign write_enable  = r_we;
  assign write_sample  = r_data;
  assign read_index    = r_read_index;

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboard bench for wave_capture: stimulus queues expected writes, a monitor pops and compares.
module tb_wave_capture;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = 16'h0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  wave_capture dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write the DUT presents must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && write_enable) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 write_address, write_sample);
      end else begin
        e = q.pop_front();
        check("wr_addr", write_address, e.addr);
        check("wr_data", write_sample, e.data);
      end
    end
  end

  // Called at posedge+1; one strobe cycle followed by one quiet cycle.
  task automatic strobe(input logic [15:0] s, input bit exp_wr,
                        input logic [8:0] a, input logic [7:0] d);
    new_sample_ready = 1'b1;
    new_sample_in    = s;
    if (exp_wr) q.push_back({a, d});
    @(posedge clk); #1;
    new_sample_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_we",   write_enable,  0);
    check("rst_addr", write_address, 0);
    check("rst_data", write_sample,  0);
    check("rst_ri",   read_index,    0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Same-sign pairs never trigger
    strobe(16'h0100, 0, 0, 0);
    strobe(16'h0200, 0, 0, 0);
    strobe(16'h8000, 0, 0, 0);
    strobe(16'hF000, 0, 0, 0);

    // Trigger on 0xFF00 -> 0x0100, then full capture into bank 1
    do_reset();
    strobe(16'hFF00, 0, 0, 0);
    strobe(16'h0100, 1, 9'h100, 8'h81);
    check("ri_capture0", read_index, 0);
    for (int k = 1; k < 256; k++)
      strobe(16'(k << 8), 1, 9'(9'h100 + k), 8'((8'h80 + k) & 8'hFF));
    for (int k = 0; k < 3; k++) strobe(16'h0500, 0, 0, 0);
    check("ri_wait", read_index, 0);

    // Display busy holds the swap; the first idle cycle flips read_index
    repeat (100) @(posedge clk);
    #1;
    check("ri_busy", read_index, 0);
    wave_display_idle = 1'b1;
    @(posedge clk); #1;
    wave_display_idle = 1'b0;
    check("ri_swap", read_index, 1);

    // Second capture targets bank 0, interrupted by reset at index 100
    strobe(16'hFF00, 0, 0, 0);
    strobe(16'h0100, 1, 9'h000, 8'h81);
    for (int k = 1; k < 100; k++)
      strobe(16'(k << 8), 1, 9'(k), 8'((8'h80 + k) & 8'hFF));
    new_sample_ready = 1'b1;
    new_sample_in    = 16'(100 << 8);
    @(posedge clk); #1;
    new_sample_ready = 1'b0;
    check("pre_rst_we",   write_enable,  1);
    check("pre_rst_addr", write_address, 9'h064);
    reset_n = 1'b0;
    #1;
    check("async_we",   write_enable,  0);
    check("async_addr", write_address, 0);
    check("async_data", write_sample,  0);
    check("async_ri",   read_index,    0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    strobe(16'hFF00, 0, 0, 0);
    strobe(16'h0100, 1, 9'h100, 8'h81);
    strobe(16'h0200, 1, 9'h101, 8'h82);

    // Constant positive input: no crossing ever occurs
    do_reset();
    for (int i = 1; i <= 5000; i++) begin
`ifdef TRIGGER_TIMEOUT_EN
      strobe(16'h1234, (i >= 1024 && i < 1280), 9'(9'h100 + i - 1024), 8'h92);
`else
      strobe(16'h1234, 0, 0, 0);
`endif
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
